melody_sequencer: RTL and testbench

Controller that sequences the piezo tone generator. It steps through a writable melody table, presents each entry's note code and pitch band to the tone generator's `note`/`pitch`/`enable` inputs for a programmed number of beats, and inserts a silent articulation gap between notes. It sits between the host/register interface and the tone generator. It is the only block driving the tone generator's inputs.

---
 rtl/melody_pkg.sv | 25 ++
 rtl/melody_ram.sv | 28 ++
 rtl/melody_sequencer.sv | 169 ++++++++++++++++
 tb/tb_melody_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// melody_pkg: shared definitions for the melody sequencer.
//   state_t        sequencer FSM states
//   *_HI / *_LO    bit positions of the fields in a 16-bit melody table entry
//   NOTE_REST      note code that plays silence
//   DUR_END        duration value that marks the end of the song
package melody_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PLAY,
    GAP
  } state_t;

  localparam int unsigned DUR_HI   = 15;
  localparam int unsigned DUR_LO   = 12;
  localparam int unsigned PITCH_HI = 11;
  localparam int unsigned PITCH_LO = 10;
  localparam int unsigned NOTE_HI  = 7;
  localparam int unsigned NOTE_LO  = 0;

  localparam logic [7:0] NOTE_REST = 8'h00;
  localparam logic [3:0] DUR_END   = 4'h0;

endpackage

// File: rtl/melody_ram.sv
// melody_ram: 2^ADDR_W x 16 melody table, one write port and one
// registered read port. A read and a write to the same address on the same
// edge return the previously stored word.
//   clk      in  clock, rising edge
//   wr_en    in  write strobe
//   wr_addr  in  write address
//   wr_data  in  write data
//   rd_addr  in  read address, sampled every edge
//   rd_data  out registered read data
module melody_ram #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps through the melody table and drives the piezo tone
// generator's note/pitch/enable inputs, holding each entry for its number of
// beats followed by a silent articulation gap.
//   CLK, RSTn           clock (rising edge), asynchronous active-low reset
//   start / stop        single-cycle playback control pulses (stop wins)
//   loop                restart at end of song; honoured only when the
//                       MELODY_LOOP_EN macro is defined
//   wr_en/wr_addr/wr_data  melody table write port
//   note, pitch, enable registered tone generator controls
//   busy                high whenever not IDLE
//   done                one-cycle pulse on natural end of song
//   play_addr           address of the current entry
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned BEAT_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 500_000
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic [7:0]        note,
  output logic [1:0]        pitch,
  output logic              enable,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] play_addr
);

  localparam int unsigned BW = $clog2(BEAT_CYCLES + 1);
  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BEAT_LOAD = BW'(BEAT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t            state;
  logic [BW-1:0]     beat_cnt;
  logic [3:0]        beats_left;
  logic [GW-1:0]     gap_cnt;
  logic [15:0]       rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              loop_act;
  logic              play_last;
  logic              next_step;
  logic              song_end;

  logic [3:0] entry_dur;
  logic [1:0] entry_pitch;
  logic [7:0] entry_note;
  logic       unused_rsvd;

  assign entry_dur   = rd_data[DUR_HI:DUR_LO];
  assign entry_pitch = rd_data[PITCH_HI:PITCH_LO];
  assign entry_note  = rd_data[NOTE_HI:NOTE_LO];
  // reserved entry bits carry no meaning
  assign unused_rsvd = ^rd_data[9:8];

`ifdef MELODY_LOOP_EN
  assign loop_act = loop;
`else
  logic unused_loop;
  assign loop_act    = 1'b0;
  assign unused_loop = loop;
`endif

  melody_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    play_last = (beat_cnt == '0) && (beats_left == '0);
    next_step = ((state == PLAY) && play_last && (GAP_CYCLES == 0)) ||
                ((state == GAP) && (gap_cnt == '0));
    song_end  = ((state == FETCH) && (entry_dur == DUR_END)) ||
                (next_step && (play_addr == ADDR_LAST));
    // The RAM is addressed with the address play_addr takes on this edge, so
    // the entry is already registered for the whole FETCH cycle and decoded
    // on its exit edge.
    if (((state == IDLE) && start) || song_end) rd_addr = '0;
    else if (next_step)                          rd_addr = play_addr + 1'b1;
    else                                         rd_addr = play_addr;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      note       <= '0;
      pitch      <= '0;
      enable     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      play_addr  <= '0;
      beat_cnt   <= '0;
      beats_left <= '0;
      gap_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state  <= IDLE;
        enable <= 1'b0;
        busy   <= 1'b0;
      end else if (song_end) begin
        if (loop_act) begin
          state     <= FETCH;
          play_addr <= '0;
        end else begin
          state  <= IDLE;
          enable <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= FETCH;
              play_addr <= '0;
              busy      <= 1'b1;
            end
          end
          FETCH: begin
            note       <= entry_note;
            pitch      <= entry_pitch;
            enable     <= (entry_note != NOTE_REST);
            beats_left <= entry_dur - 4'd1;
            beat_cnt   <= BEAT_LOAD;
            state      <= PLAY;
          end
          PLAY: begin
            if (beat_cnt != '0) begin
              beat_cnt <= beat_cnt - 1'b1;
            end else if (beats_left != '0) begin
              beats_left <= beats_left - 4'd1;
              beat_cnt   <= BEAT_LOAD;
            end else if (next_step) begin
              play_addr <= play_addr + 1'b1;
              state     <= FETCH;
            end else begin
              state   <= GAP;
              enable  <= 1'b0;
              gap_cnt <= GAP_LOAD;
            end
          end
          GAP: begin
            if (gap_cnt != '0) begin
              gap_cnt <= gap_cnt - 1'b1;
            end else begin
              play_addr <= play_addr + 1'b1;
              state     <= FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
module tb_melody_sequencer;

  localparam int unsigned AW = 3;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic [7:0]    note;
  logic [1:0]    pitch;
  logic          enable;
  logic          busy;
  logic          done;
  logic [AW-1:0] play_addr;

  always #5 CLK = ~CLK;

  melody_sequencer #(.ADDR_W(AW), .BEAT_CYCLES(4), .GAP_CYCLES(2)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .note      (note),
    .pitch     (pitch),
    .enable    (enable),
    .busy      (busy),
    .done      (done),
    .play_addr (play_addr)
  );

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          enable;
    logic [7:0]    note;
    logic [1:0]    pitch;
    logic [AW-1:0] addr;
  } obs_t;

  typedef struct {
    logic          start;
    logic          stop;
    logic          wr;
    logic [AW-1:0] wa;
    logic [15:0]   wd;
    obs_t          exp;
    string         tag;
  } step_t;

  step_t q[$];
  int    errors = 0;
  int    checks = 0;
  logic [AW-1:0] last_a;

  function automatic obs_t o(input logic b, input logic d, input logic e,
                             input logic [7:0] n, input logic [1:0] p,
                             input logic [AW-1:0] a);
    obs_t r;
    r.busy = b; r.done = d; r.enable = e; r.note = n; r.pitch = p; r.addr = a;
    return r;
  endfunction

  task automatic add(input int n, input string tag, input logic st,
                     input logic sp, input obs_t e);
    step_t s;
    s.start = st; s.stop = sp; s.wr = 1'b0; s.wa = '0; s.wd = '0;
    s.exp = e; s.tag = tag;
    for (int i = 0; i < n; i++) q.push_back(s);
  endtask

  task automatic addw(input string tag, input logic [AW-1:0] wa,
                      input logic [15:0] wd, input obs_t e);
    step_t s;
    s.start = 1'b0; s.stop = 1'b0; s.wr = 1'b1; s.wa = wa; s.wd = wd;
    s.exp = e; s.tag = tag;
    q.push_back(s);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive each step's inputs, let one edge pass, compare against the
  // expected output snapshot queued with it.
  task automatic run();
    step_t s;
    obs_t  got;
    while (q.size() > 0) begin
      s = q.pop_front();
      start = s.start; stop = s.stop;
      wr_en = s.wr; wr_addr = s.wa; wr_data = s.wd;
      tick();
      start = 1'b0; stop = 1'b0; wr_en = 1'b0;
      got = o(busy, done, enable, note, pitch, play_addr);
      checks++;
      assert (got === s.exp) else begin
        errors++;
        $error("FAIL %s: observed b%0b d%0b e%0b n%h p%0d a%0d expected b%0b d%0b e%0b n%h p%0d a%0d",
               s.tag, got.busy, got.done, got.enable, got.note, got.pitch, got.addr,
               s.exp.busy, s.exp.done, s.exp.enable, s.exp.note, s.exp.pitch, s.exp.addr);
      end
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_note", 32'(note), 32'h0);
    chk("rst_pitch", 32'(pitch), 32'h0);
    chk("rst_enable", 32'(enable), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_addr", 32'(play_addr), 32'h0);
    @(negedge CLK);
    RSTn = 1'b1;
    tick();

    // 1: single note then end of song
    wr(3'd0, 16'h1021);
    wr(3'd1, 16'h0000);
    add(1, "t1_fetch", 1'b1, 1'b0, o(1, 0, 0, 8'h00, 2'd0, 3'd0));
    add(4, "t1_play",  1'b0, 1'b0, o(1, 0, 1, 8'h21, 2'd0, 3'd0));
    add(2, "t1_gap",   1'b0, 1'b0, o(1, 0, 0, 8'h21, 2'd0, 3'd0));
    add(1, "t1_fetch2",1'b0, 1'b0, o(1, 0, 0, 8'h21, 2'd0, 3'd1));
    add(1, "t1_done",  1'b0, 1'b0, o(0, 1, 0, 8'h21, 2'd0, 3'd1));
    add(1, "t1_idle",  1'b0, 1'b0, o(0, 0, 0, 8'h21, 2'd0, 3'd1));
    run();

    // 2: two-beat rest, done 12 edges after start is sampled
    wr(3'd0, 16'h2400);
    add(1, "t2_fetch", 1'b1, 1'b0, o(1, 0, 0, 8'h21, 2'd0, 3'd0));
    add(8, "t2_play",  1'b0, 1'b0, o(1, 0, 0, 8'h00, 2'd1, 3'd0));
    add(2, "t2_gap",   1'b0, 1'b0, o(1, 0, 0, 8'h00, 2'd1, 3'd0));
    add(1, "t2_fetch2",1'b0, 1'b0, o(1, 0, 0, 8'h00, 2'd1, 3'd1));
    add(1, "t2_done",  1'b0, 1'b0, o(0, 1, 0, 8'h00, 2'd1, 3'd1));
    add(1, "t2_idle",  1'b0, 1'b0, o(0, 0, 0, 8'h00, 2'd1, 3'd1));
    run();

    // 3: full table, end at address 7 without a ninth fetch
    for (int i = 0; i < 8; i++) begin
      logic [7:0] nv;
      nv = 8'h30 + 8'(i);
      wr(3'(i), {4'h1, 2'(i), 2'b00, nv});
    end
    add(1, "t3_fetch", 1'b1, 1'b0, o(1, 0, 0, 8'h00, 2'd1, 3'd0));
    for (int i = 0; i < 8; i++) begin
      logic [7:0]    nv;
      logic [1:0]    pv;
      logic [AW-1:0] av;
      nv = 8'h30 + 8'(i);
      pv = 2'(i);
      av = 3'(i);
      add(4, "t3_play", 1'b0, 1'b0, o(1, 0, 1, nv, pv, av));
      add(2, "t3_gap",  1'b0, 1'b0, o(1, 0, 0, nv, pv, av));
      if (i < 7) add(1, "t3_fetch", 1'b0, 1'b0, o(1, 0, 0, nv, pv, av + 3'd1));
    end
    add(1, "t3_done", 1'b0, 1'b0, o(0, 1, 0, 8'h37, 2'd3, 3'd7));
    add(2, "t3_idle", 1'b0, 1'b0, o(0, 0, 0, 8'h37, 2'd3, 3'd7));
    run();

    // 4: stop in the third PLAY cycle, then replay from address 0
    add(1, "t4_fetch", 1'b1, 1'b0, o(1, 0, 0, 8'h37, 2'd3, 3'd0));
    add(2, "t4_play",  1'b0, 1'b0, o(1, 0, 1, 8'h30, 2'd0, 3'd0));
    add(1, "t4_stop",  1'b0, 1'b1, o(0, 0, 0, 8'h30, 2'd0, 3'd0));
    add(2, "t4_nodone",1'b0, 1'b0, o(0, 0, 0, 8'h30, 2'd0, 3'd0));
    add(1, "t4_refetch",1'b1, 1'b0, o(1, 0, 0, 8'h30, 2'd0, 3'd0));
    add(1, "t4_replay",1'b0, 1'b0, o(1, 0, 1, 8'h30, 2'd0, 3'd0));
    add(1, "t4_stop2", 1'b0, 1'b1, o(0, 0, 0, 8'h30, 2'd0, 3'd0));
    run();

    // 5: loop at end of song
    wr(3'd0, 16'h1021);
    wr(3'd1, 16'h0000);
    loop = 1'b1;
    add(1, "t5_fetch", 1'b1, 1'b0, o(1, 0, 0, 8'h30, 2'd0, 3'd0));
    add(4, "t5_play",  1'b0, 1'b0, o(1, 0, 1, 8'h21, 2'd0, 3'd0));
    add(2, "t5_gap",   1'b0, 1'b0, o(1, 0, 0, 8'h21, 2'd0, 3'd0));
    add(1, "t5_fetch2",1'b0, 1'b0, o(1, 0, 0, 8'h21, 2'd0, 3'd1));
`ifdef MELODY_LOOP_EN
    add(1, "t5_restart",1'b0, 1'b0, o(1, 0, 0, 8'h21, 2'd0, 3'd0));
    add(4, "t5_play2", 1'b0, 1'b0, o(1, 0, 1, 8'h21, 2'd0, 3'd0));
    add(1, "t5_stop",  1'b0, 1'b1, o(0, 0, 0, 8'h21, 2'd0, 3'd0));
    last_a = 3'd0;
`else
    add(1, "t5_done",  1'b0, 1'b0, o(0, 1, 0, 8'h21, 2'd0, 3'd1));
    add(1, "t5_idle",  1'b0, 1'b0, o(0, 0, 0, 8'h21, 2'd0, 3'd1));
    last_a = 3'd1;
`endif
    run();
    loop = 1'b0;

    // 6: start+stop together stays idle; write during FETCH plays old entry
    add(1, "t6_startstop", 1'b1, 1'b1, o(0, 0, 0, 8'h21, 2'd0, last_a));
    add(1, "t6_idle",  1'b0, 1'b0, o(0, 0, 0, 8'h21, 2'd0, last_a));
    add(1, "t6_fetch", 1'b1, 1'b0, o(1, 0, 0, 8'h21, 2'd0, 3'd0));
    addw("t6_wr_fetch", 3'd0, 16'h1844, o(1, 0, 1, 8'h21, 2'd0, 3'd0));
    add(3, "t6_play",  1'b0, 1'b0, o(1, 0, 1, 8'h21, 2'd0, 3'd0));
    add(2, "t6_gap",   1'b0, 1'b0, o(1, 0, 0, 8'h21, 2'd0, 3'd0));
    add(1, "t6_fetch2",1'b0, 1'b0, o(1, 0, 0, 8'h21, 2'd0, 3'd1));
    add(1, "t6_done",  1'b0, 1'b0, o(0, 1, 0, 8'h21, 2'd0, 3'd1));
    add(1, "t6_idle2", 1'b0, 1'b0, o(0, 0, 0, 8'h21, 2'd0, 3'd1));
    add(1, "t6_fetch3",1'b1, 1'b0, o(1, 0, 0, 8'h21, 2'd0, 3'd0));
    add(1, "t6_newdata",1'b0, 1'b0, o(1, 0, 1, 8'h44, 2'd2, 3'd0));
    add(1, "t6_stop",  1'b0, 1'b1, o(0, 0, 0, 8'h44, 2'd2, 3'd0));
    run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
